// File: rtl/bp_resolve_queue_if.sv
// Fetch/execute-facing bundle for the branch-resolution queue: push and
// resolve requests in, predictor update and flush outputs back.
interface bp_resolve_queue_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 8
);
  logic             push;
  logic             push_pred;
  logic [PC_W-1:0]  push_pc;
  logic             resolve;
  logic             resolve_taken;
  logic             full;
  logic             empty;
  logic             bp_enable;
  logic             bp_actual;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] mispredict_cnt;
  logic             err;

  modport master (
    output push, push_pred, push_pc, resolve, resolve_taken,
    input  full, empty, bp_enable, bp_actual, mispredict, redirect_pc,
           mispredict_cnt, err
  );

  modport slave (
    input  push, push_pred, push_pc, resolve, resolve_taken,
    output full, empty, bp_enable, bp_actual, mispredict, redirect_pc,
           mispredict_cnt, err
  );
endinterface

// File: rtl/bp_resolve_queue.sv
// In-order queue of fetch predictions, popped and checked on each execute resolve.
// Update/flush outputs are registered, one cycle after the resolve; push-when-full is dropped and flagged.
module bp_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  bp_resolve_queue_if.slave q
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic            mem_pred [DEPTH];
  logic [PC_W-1:0] mem_pc   [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  logic            head_pred;
  logic [PC_W-1:0] head_pc;
  logic            is_full, is_empty;
  logic            res_ok, mis, push_ok, err_set;

  always_comb begin
    head_pred = mem_pred[rd_ptr];
    head_pc   = mem_pc[rd_ptr];
    is_full   = (count == CW'(DEPTH));
    is_empty  = (count == '0);
    res_ok    = q.resolve && !is_empty;
    mis       = res_ok && (q.resolve_taken != head_pred);
    // A push alongside a mispredict is wrong-path: dropped, but not an error.
    push_ok   = q.push && !mis && (!is_full || res_ok);
    err_set   = (q.push && is_full && !res_ok) || (q.resolve && is_empty);
  end

  assign q.full  = is_full;
  assign q.empty = is_empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_pred[wr_ptr] <= q.push_pred;
      mem_pc[wr_ptr]   <= q.push_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      q.bp_enable      <= 1'b0;
      q.bp_actual      <= 1'b0;
      q.mispredict     <= 1'b0;
      q.redirect_pc    <= '0;
      q.mispredict_cnt <= '0;
      q.err            <= 1'b0;
    end else begin
      if (mis) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (res_ok)  rd_ptr <= rd_ptr + AW'(1);
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        count <= count + CW'(push_ok) - CW'(res_ok);
      end
      q.bp_enable  <= res_ok;
      q.bp_actual  <= res_ok && q.resolve_taken;
      q.mispredict <= mis;
      if (mis) begin
        q.redirect_pc <= head_pc;
        if (q.mispredict_cnt != '1) q.mispredict_cnt <= q.mispredict_cnt + CNT_W'(1);
      end
      if (err_set) q.err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed table-driven bench for bp_resolve_queue, with a CNT_W=2 twin for saturation.
module tb_bp_resolve_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        push, push_pred, resolve, resolve_taken;
  logic [15:0] push_pc;

  always #5 clk = ~clk;

  bp_resolve_queue_if #(.PC_W(16), .CNT_W(8)) qi ();
  bp_resolve_queue_if #(.PC_W(16), .CNT_W(2)) si ();

  assign qi.push = push;           assign si.push = push;
  assign qi.push_pred = push_pred; assign si.push_pred = push_pred;
  assign qi.push_pc = push_pc;     assign si.push_pc = push_pc;
  assign qi.resolve = resolve;     assign si.resolve = resolve;
  assign qi.resolve_taken = resolve_taken;
  assign si.resolve_taken = resolve_taken;

  bp_resolve_queue #(.DEPTH(4), .PC_W(16), .CNT_W(8)) dut (.clk(clk), .rst(rst), .q(qi));
  bp_resolve_queue #(.DEPTH(4), .PC_W(16), .CNT_W(2)) dut_sat (.clk(clk), .rst(rst), .q(si));

  typedef struct {
    logic        push, pred;
    logic [15:0] pc;
    logic        res, tak;
    logic        full, empty, en, act, mis;
    logic [15:0] rpc;
    logic [7:0]  cnt;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
    end
  endtask

  task automatic add(input logic p, input logic pr, input logic [15:0] pc, input logic r, input logic t,
                     input logic f, input logic e, input logic en, input logic a, input logic m,
                     input logic [15:0] rpc, input logic [7:0] c, input logic er);
    vec_t v;
    v.push = p; v.pred = pr; v.pc = pc; v.res = r; v.tak = t;
    v.full = f; v.empty = e; v.en = en; v.act = a; v.mis = m;
    v.rpc = rpc; v.cnt = c; v.err = er;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic p, input logic pr, input logic [15:0] pc, input logic r, input logic t);
    push = p; push_pred = pr; push_pc = pc; resolve = r; resolve_taken = t;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_full"}, -1, 32'(qi.full), 0);
    chk({tag, "_empty"}, -1, 32'(qi.empty), 1);
    chk({tag, "_bp_enable"}, -1, 32'(qi.bp_enable), 0);
    chk({tag, "_bp_actual"}, -1, 32'(qi.bp_actual), 0);
    chk({tag, "_mispredict"}, -1, 32'(qi.mispredict), 0);
    chk({tag, "_redirect_pc"}, -1, 32'(qi.redirect_pc), 0);
    chk({tag, "_mispredict_cnt"}, -1, 32'(qi.mispredict_cnt), 0);
    chk({tag, "_err"}, -1, 32'(qi.err), 0);
    chk({tag, "_sat_cnt"}, -1, 32'(si.mispredict_cnt), 0);
  endtask

  initial begin
    // Fill-then-drain of three, then a single correct resolve.
    add(1,1,16'h0010,0,0, 0,0,0,0,0,16'h0000,0,0);
    add(1,0,16'h0020,0,0, 0,0,0,0,0,16'h0000,0,0);
    add(1,1,16'h0030,0,0, 0,0,0,0,0,16'h0000,0,0);
    add(0,0,16'h0000,1,1, 0,0,1,1,0,16'h0000,0,0);
    add(0,0,16'h0000,1,0, 0,0,1,0,0,16'h0000,0,0);
    add(0,0,16'h0000,1,1, 0,1,1,1,0,16'h0000,0,0);
    add(1,1,16'h0100,0,0, 0,0,0,0,0,16'h0000,0,0);
    add(0,0,16'h0000,1,1, 0,1,1,1,0,16'h0000,0,0);
    add(0,0,16'h0000,0,0, 0,1,0,0,0,16'h0000,0,0);
    // Mispredict squash with a same-cycle wrong-path push.
    add(1,0,16'h0040,0,0, 0,0,0,0,0,16'h0000,0,0);
    add(1,1,16'h0050,0,0, 0,0,0,0,0,16'h0000,0,0);
    add(1,1,16'h0060,0,0, 0,0,0,0,0,16'h0000,0,0);
    add(1,1,16'h0070,1,1, 0,1,1,1,1,16'h0040,1,0);
    add(0,0,16'h0000,0,0, 0,1,0,0,0,16'h0040,1,0);
    for (int i = 0; i < 10; i++) begin
      add(1,i[0],16'h0200 + 16'(i),0,0, 0,0,0,0,0,16'h0040,1,0);
      add(0,0,16'h0000,1,i[0], 0,1,1,i[0],0,16'h0040,1,0);
    end
    // Full boundary: overflow drop, then push+correct resolve while full.
    for (int k = 0; k < 4; k++)
      add(1,1,16'h0300 + 16'(k),0,0, k == 3,0,0,0,0,16'h0040,1,0);
    add(1,0,16'h0380,0,0, 1,0,0,0,0,16'h0040,1,1);
    add(1,0,16'h0390,1,1, 1,0,1,1,0,16'h0040,1,1);
    for (int k = 0; k < 3; k++)
      add(0,0,16'h0000,1,1, 0,0,1,1,0,16'h0040,1,1);
    add(0,0,16'h0000,1,0, 0,1,1,0,0,16'h0040,1,1);
    // Resolve on empty with a simultaneous push: error, no update, push kept.
    add(1,1,16'h03A0,1,1, 0,0,0,0,0,16'h0040,1,1);
    add(0,0,16'h0000,1,0, 0,1,1,0,1,16'h03A0,2,1);
    for (int k = 0; k < 3; k++) begin
      add(1,0,16'h0400 + 16'(k),0,0, 0,0,0,0,0,(k == 0) ? 16'h03A0 : 16'h0400 + 16'(k-1),8'(2+k),1);
      add(0,0,16'h0000,1,1, 0,1,1,1,1,16'h0400 + 16'(k),8'(3+k),1);
    end

    rst = 1'b1;
    drive(0,0,16'h0000,0,0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs("reset");

    foreach (vecs[i]) begin
      drive(vecs[i].push, vecs[i].pred, vecs[i].pc, vecs[i].res, vecs[i].tak);
      @(posedge clk);
      #1;
      chk("full", i, 32'(qi.full), 32'(vecs[i].full));
      chk("empty", i, 32'(qi.empty), 32'(vecs[i].empty));
      chk("bp_enable", i, 32'(qi.bp_enable), 32'(vecs[i].en));
      chk("bp_actual", i, 32'(qi.bp_actual), 32'(vecs[i].act));
      chk("mispredict", i, 32'(qi.mispredict), 32'(vecs[i].mis));
      chk("redirect_pc", i, 32'(qi.redirect_pc), 32'(vecs[i].rpc));
      chk("mispredict_cnt", i, 32'(qi.mispredict_cnt), 32'(vecs[i].cnt));
      chk("err", i, 32'(qi.err), 32'(vecs[i].err));
    end
    drive(0,0,16'h0000,0,0);
    chk("sat_cnt", -1, 32'(si.mispredict_cnt), 3);

    // Async reset asserted while a mispredict pulse is on the outputs.
    drive(1,0,16'h0500,0,0);
    @(posedge clk); #1;
    drive(0,0,16'h0000,1,1);
    @(posedge clk); #1;
    drive(0,0,16'h0000,0,0);
    chk("pre_rst_mispredict", -1, 32'(qi.mispredict), 1);
    chk("pre_rst_redirect_pc", -1, 32'(qi.redirect_pc), 32'h0500);
    chk("pre_rst_cnt", -1, 32'(qi.mispredict_cnt), 6);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Operation resumes after reset.
    drive(1,0,16'h0600,0,0);
    @(posedge clk); #1;
    chk("post_rst_empty", -1, 32'(qi.empty), 0);
    drive(0,0,16'h0000,1,1);
    @(posedge clk); #1;
    drive(0,0,16'h0000,0,0);
    chk("post_rst_mispredict", -1, 32'(qi.mispredict), 1);
    chk("post_rst_redirect_pc", -1, 32'(qi.redirect_pc), 32'h0600);
    chk("post_rst_cnt", -1, 32'(qi.mispredict_cnt), 1);
    chk("post_rst_err", -1, 32'(qi.err), 0);
    @(posedge clk); #1;
    chk("post_rst_pulse_end", -1, 32'(qi.mispredict), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
